// File: rtl/amp_rsp_collector.sv
// Collects the amplifier result stream into a small fall-through FIFO for a downstream consumer.
// Head is visible the edge after a push; full FIFO drops new results unless popped that cycle.
module amp_rsp_collector #(
    parameter int DEPTH     = 8,
    parameter int NO_WIDTH  = 8,
    parameter int RES_WIDTH = 24
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic                          rd_val_i,
    input  logic [NO_WIDTH+RES_WIDTH-1:0] rd_data_i,
    input  logic                          clr_i,
    output logic                          out_val_o,
    output logic [NO_WIDTH+RES_WIDTH-1:0] out_data_o,
    input  logic                          out_rdy_i,
    output logic                          fifo_full_o,
    output logic                          fifo_empty_o,
    output logic [$clog2(DEPTH):0]        level_o,
    output logic                          seq_err_o,
    output logic [NO_WIDTH-1:0]           err_no_o,
    output logic                          overflow_o,
    output logic [15:0]                   rx_cnt_o,
    output logic [7:0]                    drop_cnt_o
);

    localparam int DW = NO_WIDTH + RES_WIDTH;
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DW-1:0]       mem_q [DEPTH];
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]       level_q, level_d;

    logic                first_seen_q, first_seen_d;
    logic [NO_WIDTH-1:0] exp_no_q, exp_no_d;
    logic                seq_err_q, seq_err_d;
    logic [NO_WIDTH-1:0] err_no_q, err_no_d;
    logic                ovf_q, ovf_d;
    logic [15:0]         rx_cnt_q, rx_cnt_d;
    logic [7:0]          drop_cnt_q, drop_cnt_d;

    logic                full, empty, push, pop, drop;
    logic [NO_WIDTH-1:0] rd_no;

    assign full  = (level_q == LW'(DEPTH));
    assign empty = (level_q == '0);
    assign pop   = !empty && out_rdy_i;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push  = rd_val_i && (!full || pop);
    assign drop  = rd_val_i && full && !pop;
    assign rd_no = rd_data_i[DW-1 -: NO_WIDTH];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_comb begin
        first_seen_d = first_seen_q;
        exp_no_d     = exp_no_q;
        seq_err_d    = seq_err_q;
        err_no_d     = err_no_q;
        ovf_d        = ovf_q;
        rx_cnt_d     = rx_cnt_q;
        drop_cnt_d   = drop_cnt_q;

        // Continuity tracks every amplifier result, including ones the FIFO drops.
        if (rd_val_i) begin
            if (first_seen_q && (rd_no != exp_no_q)) begin
                seq_err_d = 1'b1;
                err_no_d  = rd_no;
            end
            exp_no_d     = rd_no + NO_WIDTH'(1);
            first_seen_d = 1'b1;
        end
        if (push) rx_cnt_d = rx_cnt_q + 16'd1;
        if (drop) begin
            ovf_d = 1'b1;
            if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
        end

        // Clear overrides same-cycle events; a concurrent result still seeds the expected number.
        if (clr_i) begin
            seq_err_d    = 1'b0;
            err_no_d     = '0;
            ovf_d        = 1'b0;
            rx_cnt_d     = '0;
            drop_cnt_d   = '0;
            first_seen_d = rd_val_i;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            first_seen_q <= 1'b0;
            exp_no_q     <= '0;
            seq_err_q    <= 1'b0;
            err_no_q     <= '0;
            ovf_q        <= 1'b0;
            rx_cnt_q     <= '0;
            drop_cnt_q   <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            first_seen_q <= first_seen_d;
            exp_no_q     <= exp_no_d;
            seq_err_q    <= seq_err_d;
            err_no_q     <= err_no_d;
            ovf_q        <= ovf_d;
            rx_cnt_q     <= rx_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    // Storage needs no reset: an empty FIFO masks the head value.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= rd_data_i;
    end

    assign out_val_o    = !empty;
    assign out_data_o   = empty ? '0 : mem_q[rd_ptr_q];
    assign fifo_full_o  = full;
    assign fifo_empty_o = empty;
    assign level_o      = level_q;
    assign seq_err_o    = seq_err_q;
    assign err_no_o     = err_no_q;
    assign overflow_o   = ovf_q;
    assign rx_cnt_o     = rx_cnt_q;
    assign drop_cnt_o   = drop_cnt_q;

endmodule

// File: tb/tb_amp_rsp_collector.sv
// Bench for amp_rsp_collector: directed scenarios plus randomized traffic against a queue-based model.
module tb_amp_rsp_collector;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        rd_val = 1'b0;
    logic [31:0] rd_data = '0;
    logic        clr = 1'b0;
    logic        rdy = 1'b0;

    logic        out_val;
    logic [31:0] out_data;
    logic        full, empty, seq_err, ovf;
    logic [3:0]  level;
    logic [7:0]  err_no, drop_cnt;
    logic [15:0] rx_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    logic [31:0] mq[$];
    bit          m_first;
    logic [7:0]  m_exp;
    bit          m_err;
    logic [7:0]  m_err_no;
    bit          m_ovf;
    int          m_rx;
    int          m_drop;

    amp_rsp_collector #(.DEPTH(DEPTH), .NO_WIDTH(8), .RES_WIDTH(24)) dut (
        .clk_i(clk), .rstn_i(rstn), .rd_val_i(rd_val), .rd_data_i(rd_data), .clr_i(clr),
        .out_val_o(out_val), .out_data_o(out_data), .out_rdy_i(rdy),
        .fifo_full_o(full), .fifo_empty_o(empty), .level_o(level),
        .seq_err_o(seq_err), .err_no_o(err_no), .overflow_o(ovf),
        .rx_cnt_o(rx_cnt), .drop_cnt_o(drop_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic model_reset();
        mq.delete();
        m_first = 0; m_exp = 0; m_err = 0; m_err_no = 0;
        m_ovf = 0; m_rx = 0; m_drop = 0;
    endtask

    // Drive one cycle of inputs, let the edge happen, then advance the model.
    task automatic cycle(input bit v, input logic [31:0] d, input bit c, input bit r);
        bit pop, isfull, push, drp;
        logic [7:0] no;
        rd_val = v; rd_data = d; clr = c; rdy = r;
        @(posedge clk);
        no     = d[31:24];
        pop    = (mq.size() > 0) && r;
        isfull = (mq.size() == DEPTH);
        push   = v && (!isfull || pop);
        drp    = v && isfull && !pop;
        if (pop)  void'(mq.pop_front());
        if (push) mq.push_back(d);
        if (v) begin
            if (m_first && no != m_exp) begin m_err = 1; m_err_no = no; end
            m_exp   = no + 8'd1;
            m_first = 1;
        end
        if (push) m_rx = (m_rx + 1) % 65536;
        if (drp) begin m_ovf = 1; if (m_drop < 255) m_drop++; end
        if (c) begin
            m_err = 0; m_err_no = 0; m_ovf = 0; m_rx = 0; m_drop = 0; m_first = v;
        end
        #1;
        rd_val = 1'b0; clr = 1'b0;
    endtask

    task automatic test_reset();
        model_reset();
        rstn = 1'b0;
        #12;
        n_chk++; if (out_val !== 1'b0)   begin n_fail++; $display("FAIL reset_out_val: got %0b want 0", out_val); end
        n_chk++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        n_chk++; if (empty !== 1'b1 || full !== 1'b0 || level !== 4'd0)
            begin n_fail++; $display("FAIL reset_fifo: empty=%0b full=%0b level=%0d want 1 0 0", empty, full, level); end
        n_chk++; if (seq_err !== 1'b0 || err_no !== 8'd0 || ovf !== 1'b0)
            begin n_fail++; $display("FAIL reset_flags: seq_err=%0b err_no=%0d ovf=%0b want 0 0 0", seq_err, err_no, ovf); end
        n_chk++; if (rx_cnt !== 16'd0 || drop_cnt !== 8'd0)
            begin n_fail++; $display("FAIL reset_cnt: rx=%0d drop=%0d want 0 0", rx_cnt, drop_cnt); end
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_single();
        cycle(1, 32'h050009C4, 0, 1);
        n_chk++; if (out_val !== 1'b1 || out_data !== 32'h050009C4)
            begin n_fail++; $display("FAIL single_head: val=%0b data=%h want 1 050009c4", out_val, out_data); end
        n_chk++; if (level !== 4'd1) begin n_fail++; $display("FAIL single_level1: got %0d want 1", level); end
        cycle(0, $urandom, 0, 1);
        n_chk++; if (out_val !== 1'b0 || level !== 4'd0 || empty !== 1'b1)
            begin n_fail++; $display("FAIL single_drain: val=%0b level=%0d empty=%0b want 0 0 1", out_val, level, empty); end
        n_chk++; if (rx_cnt !== 16'd1 || seq_err !== 1'b0)
            begin n_fail++; $display("FAIL single_cnt: rx=%0d seq_err=%0b want 1 0", rx_cnt, seq_err); end
    endtask

    task automatic test_fill();
        for (int i = 0; i <= 8; i++) begin
            cycle(1, {8'(i), 24'($urandom)}, 0, 0);
            if (i == 7) begin
                n_chk++; if (full !== 1'b1 || level !== 4'd8 || ovf !== 1'b0)
                    begin n_fail++; $display("FAIL fill_full: full=%0b level=%0d ovf=%0b want 1 8 0", full, level, ovf); end
            end
        end
        n_chk++; if (ovf !== 1'b1 || drop_cnt !== 8'd1 || level !== 4'd8)
            begin n_fail++; $display("FAIL fill_drop: ovf=%0b drop=%0d level=%0d want 1 1 8", ovf, drop_cnt, level); end
        for (int k = 0; k < 8; k++) begin
            n_chk++; if (out_val !== 1'b1 || out_data[31:24] !== 8'(k) || out_data !== mq[0])
                begin n_fail++; $display("FAIL fill_order[%0d]: got %h want no %0d data %h", k, out_data, k, mq[0]); end
            cycle(0, 32'h0, 0, 1);
        end
        n_chk++; if (empty !== 1'b1 || out_val !== 1'b0)
            begin n_fail++; $display("FAIL fill_empty: empty=%0b val=%0b want 1 0", empty, out_val); end
    endtask

    task automatic test_full_pop();
        logic [31:0] newd;
        cycle(0, 32'h0, 1, 0);
        for (int i = 0; i < 8; i++) cycle(1, {8'(10 + i), 24'($urandom)}, 0, 0);
        newd = {8'd18, 24'($urandom)};
        cycle(1, newd, 0, 1);
        n_chk++; if (level !== 4'd8 || full !== 1'b1 || ovf !== 1'b0 || drop_cnt !== 8'd0)
            begin n_fail++; $display("FAIL fullpop_state: level=%0d full=%0b ovf=%0b drop=%0d want 8 1 0 0", level, full, ovf, drop_cnt); end
        for (int k = 0; k < 8; k++) begin
            if (k == 7) begin
                n_chk++; if (out_data !== newd) begin n_fail++; $display("FAIL fullpop_newentry: got %h want %h", out_data, newd); end
            end else begin
                n_chk++; if (out_data !== mq[0]) begin n_fail++; $display("FAIL fullpop_order[%0d]: got %h want %h", k, out_data, mq[0]); end
            end
            cycle(0, 32'h0, 0, 1);
        end
    endtask

    task automatic test_seq_gap();
        logic [7:0] nos[4];
        nos = '{8'd254, 8'd255, 8'd0, 8'd3};
        cycle(0, 32'h0, 1, 1);
        for (int i = 0; i < 3; i++) begin
            cycle(1, {nos[i], 24'($urandom)}, 0, 1);
            n_chk++; if (seq_err !== 1'b0) begin n_fail++; $display("FAIL seq_wrap[%0d]: seq_err=%0b want 0", i, seq_err); end
        end
        cycle(1, {nos[3], 24'($urandom)}, 0, 1);
        n_chk++; if (seq_err !== 1'b1 || err_no !== 8'd3)
            begin n_fail++; $display("FAIL seq_gap: seq_err=%0b err_no=%0d want 1 3", seq_err, err_no); end
        cycle(1, {8'd4, 24'($urandom)}, 0, 1);
        n_chk++; if (seq_err !== 1'b1 || err_no !== 8'd3)
            begin n_fail++; $display("FAIL seq_after: seq_err=%0b err_no=%0d want 1 3", seq_err, err_no); end
        cycle(0, 32'h0, 0, 1);
    endtask

    task automatic test_clear_reset();
        logic [31:0] head;
        for (int i = 0; i < 9; i++) cycle(1, {8'(5 + i), 24'($urandom)}, 0, 0);
        n_chk++; if (seq_err !== 1'b1 || ovf !== 1'b1 || drop_cnt !== 8'd1)
            begin n_fail++; $display("FAIL clr_pre: seq_err=%0b ovf=%0b drop=%0d want 1 1 1", seq_err, ovf, drop_cnt); end
        head = mq[0];
        cycle(0, 32'h0, 1, 0);
        n_chk++; if (seq_err !== 1'b0 || ovf !== 1'b0 || drop_cnt !== 8'd0 || err_no !== 8'd0 || rx_cnt !== 16'd0)
            begin n_fail++; $display("FAIL clr_flags: seq_err=%0b ovf=%0b drop=%0d err_no=%0d rx=%0d want all 0", seq_err, ovf, drop_cnt, err_no, rx_cnt); end
        n_chk++; if (level !== 4'd8 || out_data !== head)
            begin n_fail++; $display("FAIL clr_keep: level=%0d head=%h want 8 %h", level, out_data, head); end
        cycle(1, {8'd14, 24'($urandom)}, 0, 1);
        cycle(1, {8'd15, 24'($urandom)}, 0, 1);
        #2 rstn = 1'b0;
        #1;
        model_reset();
        n_chk++; if (out_val !== 1'b0 || level !== 4'd0 || empty !== 1'b1)
            begin n_fail++; $display("FAIL async_reset: val=%0b level=%0d empty=%0b want 0 0 1", out_val, level, empty); end
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 8 + 300; i++) begin
            cycle(1, {8'(i), 24'($urandom)}, 0, 0);
            if (i == 8 + 254) begin
                n_chk++; if (drop_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_reach: drop=%0d want 255", drop_cnt); end
            end
        end
        n_chk++; if (drop_cnt !== 8'd255 || ovf !== 1'b1 || level !== 4'd8)
            begin n_fail++; $display("FAIL sat_hold: drop=%0d ovf=%0b level=%0d want 255 1 8", drop_cnt, ovf, level); end
        n_chk++; if (rx_cnt !== 16'd8 || seq_err !== 1'b0)
            begin n_fail++; $display("FAIL sat_rx: rx=%0d seq_err=%0b want 8 0", rx_cnt, seq_err); end
    endtask

    task automatic test_random();
        logic [7:0] next_no;
        bit v, c, r;
        int fails_before;
        next_no = 8'($urandom);
        for (int i = 0; i < 600; i++) begin
            v = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 60) == 0);
            r = ((i / 100) % 2 == 0) ? ($urandom_range(0, 4) != 0) : ($urandom_range(0, 4) == 0);
            if (v && $urandom_range(0, 15) == 0) next_no = 8'($urandom);
            cycle(v, {next_no, 24'($urandom)}, c, r);
            if (v) next_no = next_no + 8'd1;
            fails_before = n_fail;
            n_chk++; if (out_val !== (mq.size() > 0)) n_fail++;
            n_chk++; if (out_data !== ((mq.size() > 0) ? mq[0] : 32'h0)) n_fail++;
            n_chk++; if (level !== 4'(mq.size()) || full !== (mq.size() == DEPTH) || empty !== (mq.size() == 0)) n_fail++;
            n_chk++; if (seq_err !== m_err || err_no !== m_err_no || ovf !== m_ovf) n_fail++;
            n_chk++; if (rx_cnt !== 16'(m_rx) || drop_cnt !== 8'(m_drop)) n_fail++;
            if (n_fail != fails_before)
                $display("FAIL random[%0d]: val=%0b data=%h lvl=%0d err=%0b/%0d ovf=%0b rx=%0d drop=%0d want val=%0b lvl=%0d err=%0b/%0d ovf=%0b rx=%0d drop=%0d",
                         i, out_val, out_data, level, seq_err, err_no, ovf, rx_cnt, drop_cnt,
                         mq.size() > 0, mq.size(), m_err, m_err_no, m_ovf, m_rx, m_drop);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_full_pop();
        test_seq_gap();
        test_clear_reset();
        test_saturation();
        test_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
